// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset PC and PC stride.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DELIVER = 2'd2,
        FETCH_ERR     = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Control, instruction-memory and IR-write signals of the fetch unit.
// The master modport is the fetch unit side; slave is its environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_start;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ready;
    logic [DATA_W-1:0] ir_data;
    logic              ir_wr;
    logic [ADDR_W-1:0] pc_out;
    logic              busy;
    logic              fetch_done;
    logic              fetch_err;

    modport master (
        input  fetch_start, pc_load, pc_next, imem_rdata, imem_ready,
        output imem_req, imem_addr, ir_data, ir_wr, pc_out, busy,
               fetch_done, fetch_err
    );

    modport slave (
        output fetch_start, pc_load, pc_next, imem_rdata, imem_ready,
        input  imem_req, imem_addr, ir_data, ir_wr, pc_out, busy,
               fetch_done, fetch_err
    );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait counter with synchronous clear/enable; tc flags count == TIMEOUT-1.
// Latency: tc follows the registered count; no backpressure (pure counter).
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: read one word from imem at PC, strobe it into the IR, advance PC.
// Latency: start->req 1 cycle, ready->ir_wr 1 cycle; waits on imem_ready up to TIMEOUT cycles.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                TIMEOUT  = 15
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);

    localparam logic [1:0] ST_IDLE    = FETCH_IDLE;
    localparam logic [1:0] ST_REQ     = FETCH_REQ;
    localparam logic [1:0] ST_DELIVER = FETCH_DELIVER;
    localparam logic [1:0] ST_ERR     = FETCH_ERR;
    localparam int         CNT_W      = 8;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic              imem_req_q, imem_req_d;
    logic              ir_wr_q, ir_wr_d;
    logic              fetch_err_q, fetch_err_d;
    logic              busy_q, busy_d;

    logic              ctr_clr;
    logic              ctr_en;
    logic              ctr_tc;
    logic [CNT_W-1:0]  ctr_cnt;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .cnt   (ctr_cnt),
        .tc    (ctr_tc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_data_d = ir_data_q;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A PC load in the same cycle as a fetch command takes priority.
                if (bus.pc_load) begin
                    pc_d = bus.pc_next;
                end else if (bus.fetch_start) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d = ST_REQ;
                        ctr_clr = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                if (bus.imem_ready) begin
                    ir_data_d = bus.imem_rdata;
                    state_d   = ST_DELIVER;
                end else if (ctr_tc) begin
                    state_d = ST_ERR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_DELIVER: begin
                pc_d    = pc_q + ADDR_W'(PC_INCR);
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered.
        imem_req_d  = (state_d == ST_REQ);
        ir_wr_d     = (state_d == ST_DELIVER);
        fetch_err_d = (state_d == ST_ERR);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ir_data_q   <= '0;
            imem_req_q  <= 1'b0;
            ir_wr_q     <= 1'b0;
            fetch_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_data_q   <= ir_data_d;
            imem_req_q  <= imem_req_d;
            ir_wr_q     <= ir_wr_d;
            fetch_err_q <= fetch_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.ir_data    = ir_data_q;
    assign bus.ir_wr      = ir_wr_q;
    assign bus.fetch_done = ir_wr_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.busy       = busy_q;
    assign bus.pc_out     = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fetch_start = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_next     = '0;
        bus.imem_rdata  = '0;
        bus.imem_ready  = 1'b0;
        #12;
        n_checks++; if (bus.pc_out !== 32'h3000) begin n_fail++; $display("FAIL rst_pc: got %h want 3000", bus.pc_out); end
        n_checks++; if (bus.ir_data !== 32'h0) begin n_fail++; $display("FAIL rst_ir_data: got %h want 0", bus.ir_data); end
        n_checks++; if ({bus.ir_wr, bus.fetch_done, bus.fetch_err, bus.imem_req, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {bus.ir_wr, bus.fetch_done, bus.fetch_err, bus.imem_req, bus.busy}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Memory answers two cycles after the request appears.
    task automatic test_basic_fetch();
        @(negedge clk);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req1: got %b want 1", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL basic_addr: got %h want 3000", bus.imem_addr); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.ir_wr !== 1'b0) begin n_fail++; $display("FAIL basic_req2: got req=%b wr=%b want 1/0", bus.imem_req, bus.ir_wr); end
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL basic_req3: got req=%b addr=%h want 1/3000", bus.imem_req, bus.imem_addr); end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        n_checks++; if (bus.ir_wr !== 1'b1 || bus.fetch_done !== 1'b1) begin n_fail++; $display("FAIL basic_wr: got wr=%b done=%b want 1/1", bus.ir_wr, bus.fetch_done); end
        n_checks++; if (bus.ir_data !== 32'h2008_0005) begin n_fail++; $display("FAIL basic_data: got %h want 20080005", bus.ir_data); end
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %b want 0", bus.imem_req); end
        @(negedge clk);
        n_checks++; if (bus.pc_out !== 32'h3004) begin n_fail++; $display("FAIL basic_pc: got %h want 3004", bus.pc_out); end
        n_checks++; if (bus.ir_wr !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got wr=%b busy=%b want 0/0", bus.ir_wr, bus.busy); end
        n_checks++; if (bus.ir_data !== 32'h2008_0005) begin n_fail++; $display("FAIL basic_retain: got %h want 20080005", bus.ir_data); end
    endtask

    task automatic test_pc_load_zero_wait();
        @(negedge clk);
        bus.pc_load = 1'b1;
        bus.pc_next = 32'h3010;
        @(negedge clk);
        bus.pc_load = 1'b0;
        n_checks++; if (bus.pc_out !== 32'h3010) begin n_fail++; $display("FAIL load_pc: got %h want 3010", bus.pc_out); end
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3010) begin n_fail++; $display("FAIL zw_req: got req=%b addr=%h want 1/3010", bus.imem_req, bus.imem_addr); end
        n_checks++; if (bus.ir_wr !== 1'b0) begin n_fail++; $display("FAIL zw_early_wr: got %b want 0", bus.ir_wr); end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h8C01_0004;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.ir_wr !== 1'b1 || bus.ir_data !== 32'h8C01_0004) begin n_fail++; $display("FAIL zw_wr: got wr=%b data=%h want 1/8c010004", bus.ir_wr, bus.ir_data); end
        @(negedge clk);
        n_checks++; if (bus.pc_out !== 32'h3014) begin n_fail++; $display("FAIL zw_pc: got %h want 3014", bus.pc_out); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        bus.pc_load = 1'b1;
        bus.pc_next = 32'h3002;
        @(negedge clk);
        bus.pc_load = 1'b0;
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        n_checks++; if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_err: got err=%b req=%b want 1/0", bus.fetch_err, bus.imem_req); end
        n_checks++; if (bus.pc_out !== 32'h3002 || bus.ir_data !== 32'h8C01_0004) begin n_fail++; $display("FAIL mis_state: got pc=%h data=%h want 3002/8c010004", bus.pc_out, bus.ir_data); end
        @(negedge clk);
        n_checks++; if (bus.fetch_err !== 1'b0 || bus.busy !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got err=%b busy=%b req=%b want 0/0/0", bus.fetch_err, bus.busy, bus.imem_req); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        int err_count;
        int err_at;
        int wr_count;
        @(negedge clk);
        bus.pc_load = 1'b1;
        bus.pc_next = 32'h3008;
        @(negedge clk);
        bus.pc_load = 1'b0;
        bus.fetch_start = 1'b1;
        req_cycles = 0; err_count = 0; err_at = -1; wr_count = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            bus.fetch_start = 1'b0;
            if (bus.imem_req === 1'b1) req_cycles++;
            if (bus.ir_wr === 1'b1) wr_count++;
            if (bus.fetch_err === 1'b1) begin err_count++; err_at = i; end
        end
        n_checks++; if (req_cycles != 15) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 15", req_cycles); end
        n_checks++; if (err_count != 1 || err_at != 15) begin n_fail++; $display("FAIL to_err: got count=%0d at=%0d want 1/15", err_count, err_at); end
        n_checks++; if (wr_count != 0) begin n_fail++; $display("FAIL to_no_wr: got %0d want 0", wr_count); end
        n_checks++; if (bus.pc_out !== 32'h3008 || bus.ir_data !== 32'h8C01_0004) begin n_fail++; $display("FAIL to_state: got pc=%h data=%h want 3008/8c010004", bus.pc_out, bus.ir_data); end
    endtask

    task automatic test_load_wins();
        @(negedge clk);
        bus.pc_load     = 1'b1;
        bus.fetch_start = 1'b1;
        bus.pc_next     = 32'h4000;
        @(negedge clk);
        bus.pc_load = 1'b0;
        n_checks++; if (bus.pc_out !== 32'h4000 || bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL lw_load: got pc=%h req=%b busy=%b want 4000/0/0", bus.pc_out, bus.imem_req, bus.busy); end
        @(negedge clk);
        bus.fetch_start = 1'b0;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4000) begin n_fail++; $display("FAIL lw_req: got req=%b addr=%h want 1/4000", bus.imem_req, bus.imem_addr); end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0123_4567;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.ir_wr !== 1'b1 || bus.ir_data !== 32'h0123_4567) begin n_fail++; $display("FAIL lw_wr: got wr=%b data=%h want 1/01234567", bus.ir_wr, bus.ir_data); end
        @(negedge clk);
        n_checks++; if (bus.pc_out !== 32'h4004) begin n_fail++; $display("FAIL lw_pc: got %h want 4004", bus.pc_out); end
    endtask

    // fetch_start and imem_ready held high: REQ, DELIVER, IDLE repeating.
    task automatic test_back_to_back();
        logic [5:0]  req_hist;
        logic [5:0]  wr_hist;
        logic [31:0] second_addr;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        bus.imem_ready  = 1'b1;
        bus.imem_rdata  = 32'hA5A5_0001;
        req_hist = '0; wr_hist = '0; second_addr = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_hist[i] = bus.imem_req;
            wr_hist[i]  = bus.ir_wr;
            if (i == 3) second_addr = bus.imem_addr;
        end
        bus.fetch_start = 1'b0;
        bus.imem_ready  = 1'b0;
        n_checks++; if (req_hist !== 6'b001001) begin n_fail++; $display("FAIL b2b_req: got %b want 001001", req_hist); end
        n_checks++; if (wr_hist !== 6'b010010) begin n_fail++; $display("FAIL b2b_wr: got %b want 010010", wr_hist); end
        n_checks++; if (second_addr !== 32'h4008) begin n_fail++; $display("FAIL b2b_addr: got %h want 4008", second_addr); end
        n_checks++; if (bus.pc_out !== 32'h400C) begin n_fail++; $display("FAIL b2b_pc: got %h want 400c", bus.pc_out); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_fetch();
        int strobes;
        @(negedge clk);
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400C) begin n_fail++; $display("FAIL rm_req: got req=%b addr=%h want 1/400c", bus.imem_req, bus.imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_async: got req=%b busy=%b want 0/0", bus.imem_req, bus.busy); end
        n_checks++; if (bus.pc_out !== 32'h3000) begin n_fail++; $display("FAIL rm_pc: got %h want 3000", bus.pc_out); end
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.ir_wr === 1'b1 || bus.fetch_err === 1'b1) strobes++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.ir_wr === 1'b1 || bus.fetch_err === 1'b1) strobes++;
        end
        n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL rm_no_strobe: got %0d want 0", strobes); end
        bus.fetch_start = 1'b1;
        @(negedge clk);
        bus.fetch_start = 1'b0;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rm_refetch: got req=%b addr=%h want 1/3000", bus.imem_req, bus.imem_addr); end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1111_2222;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.ir_wr !== 1'b1 || bus.ir_data !== 32'h1111_2222) begin n_fail++; $display("FAIL rm_wr: got wr=%b data=%h want 1/11112222", bus.ir_wr, bus.ir_data); end
        @(negedge clk);
        n_checks++; if (bus.pc_out !== 32'h3004) begin n_fail++; $display("FAIL rm_pc_after: got %h want 3004", bus.pc_out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_fetch();
        test_pc_load_zero_wait();
        test_misaligned();
        test_timeout();
        test_load_wins();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch transmitter for the multi-cycle CPU.
- On a fetch command from the control FSM, it reads one word from instruction memory over a ready/request handshake.
- It then drives the fetched word with a one-cycle write strobe into the instruction register, and advances the PC.
- It sits between the control unit, instruction memory and the instruction register. It is the producing end of the IR write interface.

Parameters:
- ADDR_W, 32, width of the PC and the memory address.
- DATA_W, 32, instruction word width.
- RESET_PC, 32'h0000_3000, PC value after reset.
- TIMEOUT, 15, maximum number of cycles to wait for imem_ready before aborting the fetch. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  fetch command from the control FSM; sampled only in IDLE.
- pc_load  in  1  load pc_next into the PC; accepted only in IDLE.
- pc_next  in  ADDR_W  new PC value (branch or jump target).
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  read address; equals the PC while imem_req is high.
- imem_rdata  in  DATA_W  read data; valid when imem_ready is high.
- imem_ready  in  1  memory response valid.
- ir_data  out  DATA_W  word for the instruction register.
- ir_wr  out  1  one-cycle write strobe for the instruction register.
- pc_out  out  ADDR_W  current PC.
- busy  out  1  high in any state other than IDLE.
- fetch_done  out  1  one-cycle pulse, coincident with ir_wr.
- fetch_err  out  1  one-cycle pulse on misaligned address or timeout.

Behaviour:
- Clock and reset:
  - One clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - pc_out=RESET_PC.
  - ir_data=0.
  - ir_wr, fetch_done, fetch_err, imem_req, busy=0.
  - State=IDLE, wait counter=0.
- Output timing:
  - All outputs are registered.
  - ir_data and ir_wr are stable across the rising edge on which the instruction register samples them.
- States: IDLE, REQ, DELIVER, ERR.
- IDLE:
  - If pc_load=1: pc <= pc_next. fetch_start is ignored in that same cycle (load wins).
  - Else, if fetch_start=1 and pc[1:0]==0: go to REQ, counter <= 0.
  - Else, if fetch_start=1 and pc[1:0]!=0: go to ERR. No request is issued.
- REQ:
  - imem_req=1 and imem_addr=pc, both held stable for the whole state.
  - Each cycle, if imem_ready=1: capture imem_rdata into ir_data and go to DELIVER.
  - Else, if counter==TIMEOUT-1: go to ERR.
  - Else: counter++.
  - imem_ready seen while not in REQ is ignored.
- DELIVER (exactly 1 cycle):
  - ir_wr=1 and fetch_done=1. ir_data holds the captured word.
  - pc <= pc+4, wrapping modulo 2^ADDR_W.
  - Return to IDLE.
- ERR (exactly 1 cycle):
  - fetch_err=1. PC and ir_data are unchanged.
  - Return to IDLE.
- Latency:
  - fetch_start in cycle 0 → imem_req high from cycle 1.
  - imem_ready first high in cycle k → ir_wr high in cycle k+1.
  - Minimum fetch is 3 cycles, from fetch_start to back in IDLE.
- Data retention: ir_data keeps the last delivered word until the next capture. It is never cleared except by reset.
- Inputs outside IDLE: pc_load and fetch_start are ignored. The controller must watch busy.
- Reset mid-fetch: immediate return to IDLE, imem_req drops asynchronously, PC returns to RESET_PC, and no strobe or error pulse is produced.
- Back-to-back fetches: fetch_start held high continuously re-fetches, with one IDLE cycle between fetches.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch state enum (IDLE/REQ/DELIVER/ERR);
  - RESET_PC_DEFAULT;
  - the PC increment constant 4.
- One sub-module, fetch_timeout_ctr: a clear/enable/terminal-count counter, parameterised by TIMEOUT and reused by any future data-memory access unit.
- The PC register stays inline.

Test Plan:
- Reset, then fetch_start pulse; memory returns 32'h2008_0005 with imem_ready 2 cycles after req → imem_addr=32'h3000 during REQ, ir_wr one cycle later with ir_data=32'h2008_0005, pc_out becomes 32'h3004.
- pc_load with pc_next=32'h3010, then fetch with zero-wait memory → imem_addr=32'h3010, ir_wr exactly 2 cycles after fetch_start, pc_out=32'h3014.
- pc_load with pc_next=32'h3002, then fetch_start → no imem_req, fetch_err for 1 cycle, pc_out stays 32'h3002, ir_data unchanged.
- imem_ready never asserted, TIMEOUT=15 → imem_req high for exactly 15 cycles, then a fetch_err pulse, no ir_wr, pc_out unchanged.
- pc_load and fetch_start together in IDLE with pc_next=32'h4000 → PC=32'h4000 and no request; a following fetch_start fetches from 32'h4000.
- rst_n asserted low while in REQ → imem_req drops immediately, pc_out=32'h3000, no ir_wr or fetch_err. After release, a normal fetch completes.
